pe_packet_scheduler: RTL and testbench

Clocked output scheduler for a spiking-PE node. It accepts per-location convolution results (conv location, residue, output spike, timestep), formats them into NoC data packets, and serialises them onto the single NoC injection port. After the last conv location of each timestep batch it inserts exactly one ACK packet. It sits between the PE's neuron/residue datapath and the router's local input port, and sequences that shared injection port.

---
 rtl/pe_pkt_pkg.sv | 71 +++++++
 rtl/pe_packet_scheduler.sv | 143 ++++++++++++++
 tb/tb_pe_packet_scheduler.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pe_pkt_pkg.sv
// Packet formats shared by the PE output scheduler and the router-side depacketizer.
// Field positions, packet widths and pack helpers live here so both ends agree.
package pe_pkt_pkg;

  localparam int PKT_MAX = 128;

  localparam int DIR_LSB      = 0;
  localparam int X_LSB        = 2;
  localparam int Y_LSB        = 5;
  localparam int TS_BIT       = 8;
  localparam int SPIKE_BIT    = 9;
  localparam int NODE_LSB     = 10;
  localparam int RES_LSB      = 14;
  localparam int CL_LSB       = 27;
  localparam int ACK_FLAG_BIT = 8;
  localparam int ACK_NODE_LSB = 9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_ACK  = 2'd2
  } sched_state_e;

  function automatic int pkt_w(input int filter_width);
    return 5 * filter_width + 13;
  endfunction

  function automatic int cl_w(input int filter_width);
    return 5 * filter_width - 14;
  endfunction

  // Callers cast the result down to their real packet width.
  function automatic logic [PKT_MAX-1:0] pack_data(
    input logic [PKT_MAX-1:0] conv_loc,
    input logic [12:0]        residue,
    input logic [3:0]         node,
    input logic               spike,
    input logic               ts,
    input logic [2:0]         y_hop,
    input logic [2:0]         x_hop,
    input logic [1:0]         dir
  );
    logic [PKT_MAX-1:0] p;
    p                  = conv_loc << CL_LSB;
    p[RES_LSB +: 13]   = residue;
    p[NODE_LSB +: 4]   = node;
    p[SPIKE_BIT]       = spike;
    p[TS_BIT]          = ts;
    p[Y_LSB +: 3]      = y_hop;
    p[X_LSB +: 3]      = x_hop;
    p[DIR_LSB +: 2]    = dir;
    return p;
  endfunction

  function automatic logic [PKT_MAX-1:0] pack_ack(
    input logic [3:0] node,
    input logic [2:0] y_hop,
    input logic [2:0] x_hop,
    input logic [1:0] dir
  );
    logic [PKT_MAX-1:0] p;
    p                    = '0;
    p[ACK_NODE_LSB +: 4] = node;
    p[ACK_FLAG_BIT]      = 1'b1;
    p[Y_LSB +: 3]        = y_hop;
    p[X_LSB +: 3]        = x_hop;
    p[DIR_LSB +: 2]      = dir;
    return p;
  endfunction

endpackage

// File: rtl/pe_packet_scheduler.sv
// Serialises per-location conv results onto the NoC injection port as data packets,
// closing each timestep batch with exactly one ACK packet.
module pe_packet_scheduler
  import pe_pkt_pkg::*;
#(
  parameter int           FILTER_WIDTH  = 8,
  parameter int           OUTPUT_WIDTH  = 13,
  parameter int           NUM_CONV_LOC  = 4,
  parameter logic [3:0]   PE_NODE       = 4'd0,
  parameter logic [1:0]   DIRECTION_OUT = 2'd0,
  parameter logic [2:0]   X_HOP_OUT     = 3'd0,
  parameter logic [2:0]   Y_HOP_OUT     = 3'd0,
  parameter logic [1:0]   DIRECTION_ACK = 2'd0,
  parameter logic [2:0]   X_HOP_ACK     = 3'd0,
  parameter logic [2:0]   Y_HOP_ACK     = 3'd0,
  localparam int          PKT_W         = pkt_w(FILTER_WIDTH),
  localparam int          CL_W          = cl_w(FILTER_WIDTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    res_valid,
  output logic                    res_ready,
  input  logic [CL_W-1:0]         res_conv_loc,
  input  logic [OUTPUT_WIDTH-1:0] res_residue,
  input  logic                    res_outspike,
  input  logic                    res_timestep,
  output logic                    pkt_valid,
  input  logic                    pkt_ready,
  output logic [PKT_W-1:0]        pkt_data,
  output logic                    ts_done,
  output logic                    err_ts
);

  localparam int                CNT_W    = $clog2(NUM_CONV_LOC + 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(NUM_CONV_LOC);

  sched_state_e     r_state;
  logic [PKT_W-1:0] r_pkt_data;
  logic             r_pkt_valid;
  logic             r_ts_done;
  logic             r_err_ts;
  logic [CNT_W-1:0] r_loc_cnt;
  logic             r_ack_due;
  logic             r_cur_ts;

  logic             w_res_ready;
  logic             w_accept;
  logic [CNT_W-1:0] w_next_cnt;
  logic             w_last;
  logic [PKT_W-1:0] w_data_pkt;
  logic [PKT_W-1:0] w_ack_pkt;

  assign w_data_pkt = PKT_W'(pack_data(PKT_MAX'(res_conv_loc), res_residue, PE_NODE,
                                       res_outspike, res_timestep,
                                       Y_HOP_OUT, X_HOP_OUT, DIRECTION_OUT));
  assign w_ack_pkt  = PKT_W'(pack_ack(PE_NODE, Y_HOP_ACK, X_HOP_ACK, DIRECTION_ACK));

  // A pending ACK blocks new results so it directly follows its batch's last packet.
  always_comb begin
    w_res_ready = 1'b0;
    if (reset) begin
      w_res_ready = 1'b0;
    end else if (r_state == ST_IDLE) begin
      w_res_ready = 1'b1;
    end else if (r_state == ST_DATA) begin
      w_res_ready = pkt_ready && !r_ack_due;
    end else begin
      w_res_ready = 1'b0;
    end
  end

  assign w_accept   = res_valid && w_res_ready;
  assign w_next_cnt = r_loc_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  assign w_last     = (w_next_cnt == LAST_CNT);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_pkt_data  <= '0;
      r_pkt_valid <= 1'b0;
      r_ts_done   <= 1'b0;
      r_err_ts    <= 1'b0;
      r_loc_cnt   <= '0;
      r_ack_due   <= 1'b0;
      r_cur_ts    <= 1'b0;
    end else begin
      r_ts_done <= 1'b0;
      if (w_accept) begin
        if (r_loc_cnt == '0) begin
          r_cur_ts <= res_timestep;
        end else if (res_timestep != r_cur_ts) begin
          r_err_ts <= 1'b1;
        end
        r_loc_cnt <= w_last ? '0 : w_next_cnt;
      end
      if (w_accept && w_last) begin
        r_ack_due <= 1'b1;
      end else if (r_state == ST_DATA && pkt_ready && r_ack_due) begin
        r_ack_due <= 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_pkt_data  <= w_data_pkt;
            r_pkt_valid <= 1'b1;
            r_state     <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (pkt_ready) begin
            if (r_ack_due) begin
              r_pkt_data <= w_ack_pkt;
              r_state    <= ST_ACK;
            end else if (w_accept) begin
              r_pkt_data <= w_data_pkt;
            end else begin
              r_pkt_valid <= 1'b0;
              r_state     <= ST_IDLE;
            end
          end
        end
        ST_ACK: begin
          if (pkt_ready) begin
            r_ts_done   <= 1'b1;
            r_pkt_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_pkt_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign res_ready = w_res_ready;
  assign pkt_valid = r_pkt_valid;
  assign pkt_data  = r_pkt_data;
  assign ts_done   = r_ts_done;
  assign err_ts    = r_err_ts;

endmodule

// File: tb/tb_pe_packet_scheduler.sv
// Self-checking bench: directed steps plus random traffic checked against a packet-queue model.
module tb_pe_packet_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic        a_res_valid, a_res_ready, a_res_outspike, a_res_timestep;
  logic [25:0] a_res_conv_loc;
  logic [12:0] a_res_residue;
  logic        a_pkt_valid, a_pkt_ready, a_ts_done, a_err_ts;
  logic [52:0] a_pkt_data;

  logic        b_res_valid, b_res_ready, b_res_outspike, b_res_timestep;
  logic [25:0] b_res_conv_loc;
  logic [12:0] b_res_residue;
  logic        b_pkt_valid, b_pkt_ready, b_ts_done, b_err_ts;
  logic [52:0] b_pkt_data;

  pe_packet_scheduler #(
    .FILTER_WIDTH(8), .OUTPUT_WIDTH(13), .NUM_CONV_LOC(1), .PE_NODE(4'd3),
    .DIRECTION_OUT(2'd1), .X_HOP_OUT(3'd3), .Y_HOP_OUT(3'd2),
    .DIRECTION_ACK(2'd2), .X_HOP_ACK(3'd1), .Y_HOP_ACK(3'd0)
  ) dut_a (
    .clk(clk), .reset(reset),
    .res_valid(a_res_valid), .res_ready(a_res_ready),
    .res_conv_loc(a_res_conv_loc), .res_residue(a_res_residue),
    .res_outspike(a_res_outspike), .res_timestep(a_res_timestep),
    .pkt_valid(a_pkt_valid), .pkt_ready(a_pkt_ready), .pkt_data(a_pkt_data),
    .ts_done(a_ts_done), .err_ts(a_err_ts)
  );

  pe_packet_scheduler #(
    .FILTER_WIDTH(8), .OUTPUT_WIDTH(13), .NUM_CONV_LOC(4), .PE_NODE(4'd3),
    .DIRECTION_OUT(2'd1), .X_HOP_OUT(3'd3), .Y_HOP_OUT(3'd2),
    .DIRECTION_ACK(2'd2), .X_HOP_ACK(3'd1), .Y_HOP_ACK(3'd0)
  ) dut_b (
    .clk(clk), .reset(reset),
    .res_valid(b_res_valid), .res_ready(b_res_ready),
    .res_conv_loc(b_res_conv_loc), .res_residue(b_res_residue),
    .res_outspike(b_res_outspike), .res_timestep(b_res_timestep),
    .pkt_valid(b_pkt_valid), .pkt_ready(b_pkt_ready), .pkt_data(b_pkt_data),
    .ts_done(b_ts_done), .err_ts(b_err_ts)
  );

  localparam logic [63:0] ACK_PKT = 64'h706;

  int total = 0;
  int bad   = 0;

  logic [63:0] exp_q[$];
  int          batch_cnt   = 0;
  int          data_seen   = 0;
  int          ack_seen    = 0;
  int          tsdone_seen = 0;
  logic        prev_stall  = 1'b0;
  logic [52:0] prev_data   = '0;
  logic        b_acc       = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Packet the spec's bit map gives for node 3, out route dir1/x3/y2.
  function automatic logic [63:0] exp_data(input logic [25:0] cl, input logic [12:0] r,
                                           input logic sp, input logic ts);
    return ({38'd0, cl} << 27) + ({51'd0, r} << 14) + (64'd3 << 10)
         + ({63'd0, sp} << 9) + ({63'd0, ts} << 8) + (64'd2 << 5) + (64'd3 << 2) + 64'd1;
  endfunction

  task automatic a_cycle(input logic v, input logic [25:0] cl, input logic [12:0] r,
                         input logic sp, input logic ts, input logic pr);
    @(negedge clk);
    a_res_valid = v; a_res_conv_loc = cl; a_res_residue = r;
    a_res_outspike = sp; a_res_timestep = ts; a_pkt_ready = pr;
    #1;
  endtask

  task automatic sb_cycle(input logic v, input logic [25:0] cl, input logic [12:0] r,
                          input logic sp, input logic ts, input logic pr);
    logic [63:0] e;
    @(negedge clk);
    b_res_valid = v; b_res_conv_loc = cl; b_res_residue = r;
    b_res_outspike = sp; b_res_timestep = ts; b_pkt_ready = pr;
    #1;
    if (prev_stall) begin
      chk("hold_valid", 64'(b_pkt_valid), 64'd1);
      chk("hold_data", 64'(b_pkt_data), 64'(prev_data));
    end
    if (b_ts_done) tsdone_seen++;
    if (b_pkt_valid && b_pkt_ready) begin
      chk("pkt_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("pkt_data", 64'(b_pkt_data), e);
        if (e == ACK_PKT) ack_seen++;
        else data_seen++;
      end
    end
    prev_stall = b_pkt_valid && !b_pkt_ready;
    prev_data  = b_pkt_data;
    b_acc      = v && b_res_ready;
    if (b_acc) begin
      exp_q.push_back(exp_data(cl, r, sp, ts));
      batch_cnt++;
      if (batch_cnt == 4) begin
        exp_q.push_back(ACK_PKT);
        batch_cnt = 0;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    a_res_valid = 1'b0; a_pkt_ready = 1'b0;
    b_res_valid = 1'b0; b_pkt_ready = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_a_res_ready", 64'(a_res_ready), 64'd0);
    chk("rst_a_pkt_valid", 64'(a_pkt_valid), 64'd0);
    chk("rst_a_pkt_data", 64'(a_pkt_data), 64'd0);
    chk("rst_b_res_ready", 64'(b_res_ready), 64'd0);
    chk("rst_b_pkt_valid", 64'(b_pkt_valid), 64'd0);
    chk("rst_b_pkt_data", 64'(b_pkt_data), 64'd0);
    chk("rst_b_ts_done", 64'(b_ts_done), 64'd0);
    chk("rst_b_err_ts", 64'(b_err_ts), 64'd0);
    reset = 1'b0;
    exp_q.delete();
    batch_cnt  = 0;
    prev_stall = 1'b0;
  endtask

  task automatic feed(input int n, input bit rnd, input bit flip2);
    int got = 0;
    int cyc = 0;
    logic v, pr, ts;
    while (got < n && cyc < 20 * n + 50) begin
      v  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      pr = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      ts = flip2 ? (got == 1) : 1'((got / 4) % 2);
      sb_cycle(v, 26'($urandom), 13'($urandom), 1'($urandom_range(0, 1)), ts, pr);
      if (b_acc) got++;
      cyc++;
    end
    chk("feed_count", 64'(got), 64'(n));
  endtask

  task automatic drain();
    int cyc = 0;
    while (exp_q.size() != 0 && cyc < 100) begin
      sb_cycle(1'b0, 26'd0, 13'd0, 1'b0, 1'b0, 1'b1);
      cyc++;
    end
    sb_cycle(1'b0, 26'd0, 13'd0, 1'b0, 1'b0, 1'b1);
    sb_cycle(1'b0, 26'd0, 13'd0, 1'b0, 1'b0, 1'b1);
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    logic [6:0] rr_exp;
    logic [6:0] pv_exp;
    int n;
    int d0, a0;
    reset = 1'b1;
    a_res_valid = 1'b0; a_res_conv_loc = '0; a_res_residue = '0;
    a_res_outspike = 1'b0; a_res_timestep = 1'b0; a_pkt_ready = 1'b0;
    b_res_valid = 1'b0; b_res_conv_loc = '0; b_res_residue = '0;
    b_res_outspike = 1'b0; b_res_timestep = 1'b0; b_pkt_ready = 1'b0;
    do_reset();

    // NUM_CONV_LOC=1: one data packet then its ACK, then a single ts_done pulse.
    a_cycle(1'b1, 26'd5, 13'h0A5, 1'b1, 1'b1, 1'b0);
    chk("a_idle_ready", 64'(a_res_ready), 64'd1);
    chk("a_idle_valid", 64'(a_pkt_valid), 64'd0);
    a_cycle(1'b0, 26'd0, 13'd0, 1'b0, 1'b0, 1'b0);
    chk("a_data_valid", 64'(a_pkt_valid), 64'd1);
    chk("a_data_pkt", 64'(a_pkt_data), 64'h2829_4F4D);
    chk("a_data_ready", 64'(a_res_ready), 64'd0);
    a_cycle(1'b0, 26'd0, 13'd0, 1'b0, 1'b0, 1'b1);
    chk("a_data_hold", 64'(a_pkt_data), 64'h2829_4F4D);
    a_cycle(1'b0, 26'd0, 13'd0, 1'b0, 1'b0, 1'b1);
    chk("a_ack_valid", 64'(a_pkt_valid), 64'd1);
    chk("a_ack_pkt", 64'(a_pkt_data), ACK_PKT);
    chk("a_ack_ready", 64'(a_res_ready), 64'd0);
    a_cycle(1'b0, 26'd0, 13'd0, 1'b0, 1'b0, 1'b0);
    chk("a_ts_done_hi", 64'(a_ts_done), 64'd1);
    chk("a_after_valid", 64'(a_pkt_valid), 64'd0);
    a_cycle(1'b0, 26'd0, 13'd0, 1'b0, 1'b0, 1'b0);
    chk("a_ts_done_lo", 64'(a_ts_done), 64'd0);
    chk("a_err_ts", 64'(a_err_ts), 64'd0);

    // NUM_CONV_LOC=4 back-to-back with pkt_ready held high.
    rr_exp = 7'b1001111;
    pv_exp = 7'b0111110;
    n = 0;
    for (int k = 0; k < 7; k++) begin
      sb_cycle(n < 4, 26'(n + 10), 13'(n * 7 + 1), 1'(n % 2), 1'b0, 1'b1);
      chk($sformatf("b2b_res_ready_%0d", k), 64'(b_res_ready), 64'(rr_exp[k]));
      chk($sformatf("b2b_pkt_valid_%0d", k), 64'(b_pkt_valid), 64'(pv_exp[k]));
      if (b_acc) n++;
    end
    chk("b2b_data_seen", 64'(data_seen), 64'd4);
    chk("b2b_ack_seen", 64'(ack_seen), 64'd1);
    chk("b2b_ts_done", 64'(tsdone_seen), 64'd1);

    // Timestep flips on the second result of a batch.
    d0 = data_seen;
    sb_cycle(1'b0, 26'd0, 13'd0, 1'b0, 1'b0, 1'b1);
    chk("err_before", 64'(b_err_ts), 64'd0);
    feed(4, 1'b0, 1'b1);
    drain();
    chk("err_set", 64'(b_err_ts), 64'd1);
    chk("err_pkts", 64'(data_seen - d0), 64'd4);
    sb_cycle(1'b0, 26'd0, 13'd0, 1'b0, 1'b0, 1'b0);
    chk("err_sticky", 64'(b_err_ts), 64'd1);

    // Reset after 2 of 4 results with a packet stalled.
    feed(2, 1'b0, 1'b0);
    sb_cycle(1'b0, 26'd0, 13'd0, 1'b0, 1'b0, 1'b0);
    chk("mid_stalled", 64'(b_pkt_valid), 64'd1);
    do_reset();
    a0 = ack_seen; d0 = data_seen;
    feed(3, 1'b0, 1'b0);
    drain();
    chk("mid_no_early_ack", 64'(ack_seen - a0), 64'd0);
    feed(1, 1'b0, 1'b0);
    drain();
    chk("mid_ack_after_4th", 64'(ack_seen - a0), 64'd1);
    chk("mid_data", 64'(data_seen - d0), 64'd4);

    // Random traffic with 50% backpressure.
    a0 = ack_seen; d0 = data_seen; tsdone_seen = 0;
    feed(1000, 1'b1, 1'b0);
    drain();
    chk("rnd_data", 64'(data_seen - d0), 64'd1000);
    chk("rnd_acks", 64'(ack_seen - a0), 64'd250);
    chk("rnd_ts_done", 64'(tsdone_seen), 64'd250);
    chk("rnd_err_ts", 64'(b_err_ts), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
